// File: rtl/uart_rx_deframer.sv
// UART receiver: 2-flop synchronised line, start-edge detect, 3-sample mid-bit majority vote,
// 8N1 / 8P1 deframing with registered single-cycle result pulses.
module uart_rx_deframer #(
    parameter int PRESCALE = 8,
    parameter int DATA_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RX_IN,
    input  logic              PAR_EN,
    input  logic              PAR_TYP,
    output logic [DATA_W-1:0] P_DATA,
    output logic              data_valid,
    output logic              par_err,
    output logic              stp_err,
    output logic              busy
);
    localparam int CNT_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] SMP0     = CNT_W'(PRESCALE/2 - 1);
    localparam logic [CNT_W-1:0] SMP1     = CNT_W'(PRESCALE/2);
    localparam logic [CNT_W-1:0] VOTE     = CNT_W'(PRESCALE/2 + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state;
    logic              sync1, rx_s, rx_prev;
    logic [CNT_W-1:0]  edge_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic              smp0, smp1;
    logic [DATA_W-1:0] data_reg;
    logic              par_en_q, par_typ_q, par_bad;
    logic              start_det, vote_pt, bit_val, par_exp;

    assign start_det = rx_prev & ~rx_s;
    assign vote_pt   = (edge_cnt == VOTE);
    // third sample is the live synchronised line, so the vote lands on the VOTE count itself
    assign bit_val   = (smp0 & smp1) | (smp0 & rx_s) | (smp1 & rx_s);
    assign par_exp   = par_typ_q ? ^data_reg : ~^data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= RX_IN;
            rx_s    <= sync1;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp0 <= 1'b1;
            smp1 <= 1'b1;
        end else if (state != IDLE) begin
            if (edge_cnt == SMP0) smp0 <= rx_s;
            if (edge_cnt == SMP1) smp1 <= rx_s;
        end
    end

    // State advances on the vote count; edge_cnt free-runs per bit so bit timing is unaffected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            data_reg   <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_bad    <= 1'b0;
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            if (state != IDLE)
                edge_cnt <= (edge_cnt == CNT_LAST) ? '0 : edge_cnt + 1'b1;

            case (state)
                IDLE: begin
                    edge_cnt <= '0;
                    bit_cnt  <= '0;
                    if (start_det) begin
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
                        par_bad   <= 1'b0;
                        busy      <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    if (vote_pt) begin
                        if (bit_val) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (vote_pt) begin
                        data_reg[bit_cnt] <= bit_val;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            state   <= par_en_q ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (vote_pt) begin
                        par_bad <= (bit_val != par_exp);
                        state   <= STOP;
                    end
                end
                STOP: begin
                    // leave immediately so a start edge at the nominal stop end is caught
                    if (vote_pt) begin
                        if (bit_val && !par_bad) begin
                            P_DATA     <= data_reg;
                            data_valid <= 1'b1;
                        end
                        par_err <= par_bad;
                        stp_err <= ~bit_val;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed + randomized bench for uart_rx_deframer: frames are described at byte level and the
// expected result pulses (time, kind, byte) are predicted from the frame rules.
module tb_uart_rx_deframer;
    localparam int P = 8;
    localparam int LAT = 9*P + P/2 + 4;

    logic       clk = 1'b0;
    logic       rst_n, RX_IN, PAR_EN, PAR_TYP;
    logic [7:0] P_DATA;
    logic       data_valid, par_err, stp_err, busy;

    uart_rx_deframer #(.PRESCALE(P), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
        .P_DATA(P_DATA), .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         t;
        logic       dv;
        logic       pe;
        logic       se;
        logic [7:0] pd;
    } ev_t;

    ev_t obs_q[$];
    ev_t exp_q[$];

    always @(negedge clk)
        if (data_valid !== 1'b0 || par_err !== 1'b0 || stp_err !== 1'b0)
            obs_q.push_back('{cyc, data_valid, par_err, stp_err, P_DATA});

    int         checks = 0;
    int         errors = 0;
    logic [7:0] model_pd = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        RX_IN = b;
        tick(P);
    endtask

    // Drives one frame starting at a negedge; predicts its result pulse from the frame content.
    task automatic send_frame(input logic [7:0] d, input bit pe, input bit pt,
                              input bit bad_par, input bit bad_stop);
        int   st;
        logic pbit;
        bit   ok;
        PAR_EN  = pe;
        PAR_TYP = pt;
        st = cyc + 1;
        drive_bit(1'b0);
        PAR_EN  = 1'($urandom);
        PAR_TYP = 1'($urandom);
        chk("busy_mid", busy, 1);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (pe) begin
            pbit = (pt ? ^d : ~^d) ^ bad_par;
            drive_bit(pbit);
        end
        drive_bit(!bad_stop);
        ok = !(pe && bad_par) && !bad_stop;
        if (ok) model_pd = d;
        exp_q.push_back('{st + LAT + (pe ? P : 0), ok, pe && bad_par, bad_stop, model_pd});
    endtask

    task automatic score(input string tag);
        int n;
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_time"},   obs_q[i].t,  exp_q[i].t);
            chk({tag, "_dv"},     obs_q[i].dv, exp_q[i].dv);
            chk({tag, "_perr"},   obs_q[i].pe, exp_q[i].pe);
            chk({tag, "_serr"},   obs_q[i].se, exp_q[i].se);
            chk({tag, "_pdata"},  obs_q[i].pd, exp_q[i].pd);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] d;
        bit         pe, pt, bp, bs;
        int         gap;

        rst_n = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        tick(3);
        chk("rst_pdata", P_DATA, 0);
        chk("rst_dv", data_valid, 0);
        chk("rst_perr", par_err, 0);
        chk("rst_serr", stp_err, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick(4);

        // basic frame, no parity
        send_frame(8'hA5, 0, 0, 0, 0);
        RX_IN = 1'b1; tick(12);
        chk("basic_busy", busy, 0);
        chk("basic_pdata", P_DATA, 8'hA5);
        score("basic");

        // even parity good, then bad parity
        send_frame(8'h3C, 1, 1, 0, 0);
        RX_IN = 1'b1; tick(5);
        send_frame(8'h3C, 1, 1, 1, 0);
        RX_IN = 1'b1; tick(12);
        chk("par_hold", P_DATA, 8'h3C);
        score("parity");

        // stop bit low, then line held low: no retrigger
        send_frame(8'h55, 0, 0, 0, 1);
        tick(40);
        chk("stop_busy", busy, 0);
        RX_IN = 1'b1; tick(10);
        score("stop");

        // 2-cycle start glitch
        RX_IN = 1'b0; tick(2);
        RX_IN = 1'b1; tick(30);
        chk("glitch_busy", busy, 0);
        chk("glitch_pdata", P_DATA, model_pd);
        score("glitch");

        // back-to-back odd-parity frames, zero idle
        send_frame(8'h00, 1, 0, 0, 0);
        send_frame(8'hFF, 1, 0, 0, 0);
        RX_IN = 1'b1; tick(12);
        if (obs_q.size() >= 2) chk("b2b_gap", obs_q[1].t - obs_q[0].t, 11*P);
        else                   chk("b2b_n", obs_q.size(), 2);
        chk("b2b_pdata", P_DATA, 8'hFF);
        score("b2b");

        // reset during data bit 4 of 0x81
        PAR_EN = 1'b0;
        drive_bit(1'b0);
        drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b0); drive_bit(1'b0);
        RX_IN = 1'b0; tick(P/2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pdata", P_DATA, 0);
        chk("mid_rst_dv", data_valid, 0);
        chk("mid_rst_perr", par_err, 0);
        chk("mid_rst_serr", stp_err, 0);
        chk("mid_rst_busy", busy, 0);
        model_pd = 8'h00;
        @(negedge clk);
        RX_IN = 1'b1; tick(4);
        rst_n = 1'b1; tick(60);
        score("abort");
        send_frame(8'h81, 0, 0, 0, 0);
        RX_IN = 1'b1; tick(12);
        chk("rerun_pdata", P_DATA, 8'h81);
        score("rerun");

        // randomized frames with random parity setup, corruption and idle gaps
        for (int k = 0; k < 24; k++) begin
            d   = 8'($urandom);
            pe  = 1'($urandom_range(0, 1));
            pt  = 1'($urandom_range(0, 1));
            bp  = pe && ($urandom_range(0, 3) == 0);
            bs  = ($urandom_range(0, 5) == 0);
            send_frame(d, pe, pt, bp, bs);
            gap = bs ? $urandom_range(4, 12) : $urandom_range(0, 12);
            if (gap > 0) begin
                RX_IN = 1'b1;
                tick(gap);
            end
        end
        RX_IN = 1'b1; tick(20);
        chk("rand_busy", busy, 0);
        chk("rand_pdata", P_DATA, model_pd);
        score("rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
